cdc_stable_capture: RTL and testbench
=====================================

// Module: cdc_stable_capture
// PURPOSE
//  Destination-domain consumer of the two-flop multi-bit cdc_synchronizer output.
//  - Bits of a synchronized bus can resolve on different cycles; this block accepts a
//    value only after it has held steady for STABLE_CYCLES consecutive clocks.
//  - It presents each newly qualified value once on a valid/ready stream.
//  - It counts values that were overwritten before the consumer accepted them.
// PARAMETERS
//  WIDTH         8    data width; must equal the upstream synchronizer WIDTH
//  STABLE_CYCLES 2    number of consecutive equal samples required to qualify; legal range 1..255
//  RESET_VAL     '0   reset value of the sample/committed/out_data registers; width WIDTH
//  DROP_W        16   width of the saturating dropped-value counter
// PORTS
//  out_clk      in   1       destination clock; the single clock of this block
//  out_reset_n  in   1       asynchronous active-low reset; deassertion pre-synchronized to out_clk
//  sync_data    in   WIDTH   output of cdc_synchronizer
//  out_data     out  WIDTH   qualified value; held constant while out_valid=1 and out_ready=0
//  out_valid    out  1       qualified value pending
//  out_ready    in   1       consumer accepts out_data when out_valid & out_ready
//  change_pulse out  1       one-cycle pulse on every commit
//  stable       out  1       1 while the stability counter is saturated at STABLE_CYCLES
//  drop_cnt     out  DROP_W  commits that overwrote an unaccepted value; saturates at all-ones
// BEHAVIOUR
//  Reset (async, out_reset_n=0): all state is cleared immediately.
//  - smp, committed, out_data <= RESET_VAL.
//  - cnt, drop_cnt <= 0; out_valid, change_pulse, stable <= 0; output FSM <= OUT_IDLE.
//  - A reset mid-transfer discards the pending value without incrementing drop_cnt.
//  Stability filter, every clock:
//  - sync_data != smp: smp <= sync_data, cnt <= 0.
//  - else, if cnt < STABLE_CYCLES: cnt <= cnt+1. Otherwise cnt holds (saturates).
//  - stable = (cnt == STABLE_CYCLES), registered.
//  Commit:
//  - Condition: cnt==STABLE_CYCLES & sync_data==smp & smp!=committed.
//  - Effect: committed <= smp, out_data <= smp, change_pulse <= 1 for one cycle.
//  - A value equal to the last committed value never re-commits (no duplicate output).
//  - A glitch that returns to the committed value produces no commit.
//  Latency: a new value first sampled at edge E and held steady is committed at edge
//    E+STABLE_CYCLES+1. out_valid rises after that edge. Example: STABLE_CYCLES=2 -> 3 clocks.
//  Output FSM (enum out_state_t):
//  - OUT_IDLE: out_valid=0. On commit -> OUT_VALID.
//  - OUT_VALID: out_valid=1. Transitions:
//      ready & !commit  -> OUT_IDLE
//      ready & commit   -> stay OUT_VALID; old value transferred, new loaded, no drop
//      !ready & commit  -> stay; out_data overwritten (latest wins), drop_cnt +1 saturating
//      !ready & !commit -> stay; out_data held
//  Widths: cnt is $clog2(STABLE_CYCLES+1) bits. drop_cnt never wraps.
//  No combinational path from any input to any output; all outputs are registered.
// STRUCTURE
//  Package cdc_sync_pkg holds:
//  - typedef enum logic [0:0] {OUT_IDLE, OUT_VALID} out_state_t
//  - localparam MAX_STABLE_CYCLES = 255
//  - function sat_inc(), a saturating increment used for drop_cnt
//  Sub-module cdc_stable_filter (smp/cnt/stable logic, emits a qualified value and a
//  qualify strobe). The top level holds commit compare, output FSM and drop_cnt.
//  Elaboration check: $error if STABLE_CYCLES<1 or STABLE_CYCLES>MAX_STABLE_CYCLES.
// TESTING
//  1 Reset, then sync_data=8'h00 held -> no commit ever; out_valid=0; stable=1 after 2 clks.
//  2 STABLE_CYCLES=2, ready=1, sync_data 00->A5 at edge E -> commit at E+3; out_data=A5;
//    change_pulse high 1 cycle; out_valid high 1 cycle.
//  3 Skew: sync_data 00->81->A5 on consecutive cycles, then held -> exactly one commit,
//    of A5 (81 never appears); 1-cycle glitch 00->FF->00 -> no commit.
//  4 ready=0, commit A5 then 3C -> out_data=3C, drop_cnt=1. Assert ready in the same cycle
//    as a 3rd commit 77 -> 3C accepted, out_data=77, out_valid stays 1, drop_cnt stays 1.
//  5 DROP_W=2, ready=0, 5 distinct commits -> drop_cnt=3 (saturated, no wrap).
//  6 Assert out_reset_n=0 while out_valid=1 -> out_valid=0 with no clock edge needed;
//    out_data=RESET_VAL; drop_cnt=0; the same value after release commits normally.

Source files
------------

// File: rtl/cdc_sync_pkg.sv
// Shared types and helpers for the destination-domain capture path.
//   out_state_t       : output stream FSM state
//   MAX_STABLE_CYCLES : upper legal bound for the stability filter depth
//   sat_inc()         : saturating increment of a w-bit value (w <= 32)
package cdc_sync_pkg;

    typedef enum logic [0:0] {
        OUT_IDLE  = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

    localparam int MAX_STABLE_CYCLES = 255;

    // Increment v, treating it as a w-bit counter that sticks at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cdc_stable_capture_if.sv
// Valid/ready stream carrying qualified values out of cdc_stable_capture.
//   out_data  : qualified value, held while out_valid & !out_ready
//   out_valid : value pending
//   out_ready : consumer accepts on out_valid & out_ready
// master = producer (the capture block), slave = consumer.
interface cdc_stable_capture_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/cdc_stable_filter.sv
// Stability filter for a synchronized multi-bit bus.
// Tracks the last sampled value (smp) and how many consecutive clocks it has
// been seen again (cnt, saturating at STABLE_CYCLES).
//   out_clk, out_reset_n : clock / async active-low reset
//   sync_data            : synchronizer output
//   qual_data            : value currently being qualified (smp)
//   qual                 : smp has held STABLE_CYCLES clocks and still matches input
//   stable               : registered, 1 while cnt is saturated
module cdc_stable_filter
    import cdc_sync_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               STABLE_CYCLES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             out_clk,
    input  logic             out_reset_n,
    input  logic [WIDTH-1:0] sync_data,
    output logic [WIDTH-1:0] qual_data,
    output logic             qual,
    output logic             stable
);
    localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [WIDTH-1:0] smp;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             same;

    always_comb begin
        same    = (sync_data == smp);
        cnt_nxt = cnt;
        if (!same)
            cnt_nxt = '0;
        else if (cnt != CNT_MAX)
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge out_clk or negedge out_reset_n) begin
        if (!out_reset_n) begin
            smp    <= RESET_VAL;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            smp    <= sync_data;
            cnt    <= cnt_nxt;
            // Registered copy of (cnt == CNT_MAX), aligned with cnt itself.
            stable <= (cnt_nxt == CNT_MAX);
        end
    end

    // The live input must still match so a change on the qualifying edge
    // restarts the filter instead of committing.
    assign qual      = (cnt == CNT_MAX) && same;
    assign qual_data = smp;

endmodule

// File: rtl/cdc_stable_capture.sv
// Destination-domain consumer of a multi-bit synchronizer output.
// Accepts a value once it has held for STABLE_CYCLES clocks, presents each new
// value once on a valid/ready stream, and counts values overwritten before the
// consumer took them.
//   out_clk, out_reset_n : clock / async active-low reset
//   sync_data            : synchronizer output
//   out_if (master)      : out_data / out_valid / out_ready stream
//   change_pulse         : one-cycle pulse per commit
//   stable               : stability counter saturated
//   drop_cnt             : saturating count of overwritten pending values
module cdc_stable_capture
    import cdc_sync_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               STABLE_CYCLES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int unsigned      DROP_W        = 16
) (
    input  logic                  out_clk,
    input  logic                  out_reset_n,
    input  logic [WIDTH-1:0]      sync_data,
    cdc_stable_capture_if.master  out_if,
    output logic                  change_pulse,
    output logic                  stable,
    output logic [DROP_W-1:0]     drop_cnt
);
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > MAX_STABLE_CYCLES) begin : g_bad_stable
        $error("cdc_stable_capture: STABLE_CYCLES out of range 1..255");
    end
    if (DROP_W < 1 || DROP_W > 32) begin : g_bad_drop
        $error("cdc_stable_capture: DROP_W out of range 1..32");
    end

    logic [WIDTH-1:0] qual_data;
    logic             qual;
    logic [WIDTH-1:0] committed;
    logic [WIDTH-1:0] data_q;
    logic             commit;
    logic             drop;
    out_state_t       state, state_nxt;

    cdc_stable_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES),
        .RESET_VAL     (RESET_VAL)
    ) u_filter (
        .out_clk     (out_clk),
        .out_reset_n (out_reset_n),
        .sync_data   (sync_data),
        .qual_data   (qual_data),
        .qual        (qual),
        .stable      (stable)
    );

    // Re-qualifying the last committed value (e.g. after a glitch) is not news.
    assign commit = qual && (qual_data != committed);

    always_comb begin
        state_nxt = state;
        drop      = 1'b0;
        case (state)
            OUT_IDLE: begin
                if (commit)
                    state_nxt = OUT_VALID;
            end
            OUT_VALID: begin
                if (out_if.out_ready && !commit)
                    state_nxt = OUT_IDLE;
                // Pending value replaced without being taken.
                drop = commit && !out_if.out_ready;
            end
            default: state_nxt = OUT_IDLE;
        endcase
    end

    always_ff @(posedge out_clk or negedge out_reset_n) begin
        if (!out_reset_n) begin
            state        <= OUT_IDLE;
            committed    <= RESET_VAL;
            data_q       <= RESET_VAL;
            change_pulse <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            change_pulse <= commit;
            if (commit) begin
                committed <= qual_data;
                data_q    <= qual_data;
            end
            if (drop)
                drop_cnt <= DROP_W'(sat_inc(32'(drop_cnt), DROP_W));
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = (state == OUT_VALID);

endmodule

// File: tb/tb_cdc_stable_capture.sv
module tb_cdc_stable_capture;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sd = 8'h00;
    logic       rdy = 1'b0;

    logic        cp0, st0, cp2, st2;
    logic [15:0] drop0;
    logic [1:0]  drop2;

    int checks = 0;
    int fails  = 0;

    cdc_stable_capture_if #(.WIDTH(8)) if0 ();
    cdc_stable_capture_if #(.WIDTH(8)) if2 ();
    assign if0.out_ready = rdy;
    assign if2.out_ready = rdy;

    cdc_stable_capture #(.WIDTH(8), .STABLE_CYCLES(S), .RESET_VAL(8'h00), .DROP_W(16)) dut (
        .out_clk(clk), .out_reset_n(rst_n), .sync_data(sd), .out_if(if0),
        .change_pulse(cp0), .stable(st0), .drop_cnt(drop0));

    cdc_stable_capture #(.WIDTH(8), .STABLE_CYCLES(S), .RESET_VAL(8'h00), .DROP_W(2)) dut2 (
        .out_clk(clk), .out_reset_n(rst_n), .sync_data(sd), .out_if(if2),
        .change_pulse(cp2), .stable(st2), .drop_cnt(drop2));

    always #5 clk = ~clk;

    // Reference model: a value commits once S+2 consecutive samples agree
    // (history window) and it differs from the last committed value.
    logic [7:0] hist[$];
    logic [7:0] com_m, data_m;
    bit         valid_m, pulse_m, stable_m;
    int         drop_m, drop2_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit win_eq(input logic [7:0] v);
        if (hist.size() < S + 1) return 1'b0;
        for (int i = 1; i <= S + 1; i++)
            if (hist[hist.size() - i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(8'h00);
        com_m = 8'h00; data_m = 8'h00;
        valid_m = 0; pulse_m = 0; stable_m = 0;
        drop_m = 0; drop2_m = 0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":data"},   32'(if0.out_data),  32'(data_m));
        chk({ph, ":valid"},  32'(if0.out_valid), 32'(valid_m));
        chk({ph, ":pulse"},  32'(cp0),           32'(pulse_m));
        chk({ph, ":stable"}, 32'(st0),           32'(stable_m));
        chk({ph, ":drop"},   32'(drop0),         32'(drop_m));
        chk({ph, ":drop2"},  32'(drop2),         32'(drop2_m));
        chk({ph, ":valid2"}, 32'(if2.out_valid), 32'(valid_m));
    endtask

    task automatic step(input string ph, input logic [7:0] v, input bit r);
        bit commit;
        sd = v; rdy = r;
        @(posedge clk);
        commit = win_eq(v) && (v != com_m);
        if (commit) begin
            if (valid_m && !r) begin
                if (drop_m < 65535) drop_m++;
                if (drop2_m < 3) drop2_m++;
            end
            valid_m = 1; data_m = v; com_m = v;
        end else if (valid_m && r) begin
            valid_m = 0;
        end
        pulse_m = commit;
        hist.push_back(v);
        if (hist.size() > 16) void'(hist.pop_front());
        stable_m = win_eq(v);
        #1;
        check_all(ph);
    endtask

    task automatic hold(input string ph, input logic [7:0] v, input int n, input bit r);
        for (int i = 0; i < n; i++) step(ph, v, r);
    endtask

    // Async reset asserted mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset(input string ph);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({ph, ":rst_valid"}, 32'(if0.out_valid), 32'd0);
        chk({ph, ":rst_data"},  32'(if0.out_data),  32'd0);
        chk({ph, ":rst_drop"},  32'(drop0),         32'd0);
        chk({ph, ":rst_pulse"}, 32'(cp0),           32'd0);
        chk({ph, ":rst_stable"}, 32'(st0),          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_all("t0");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: reset value held -> never commits, stable after 2 clocks
        step("t1", 8'h00, 1'b1);
        step("t1", 8'h00, 1'b1);
        chk("t1:stable2", 32'(st0), 32'd1);
        hold("t1", 8'h00, 4, 1'b1);

        // 2: 00 -> A5, commit three clocks after first sample
        do_reset("t2");
        hold("t2", 8'h00, 3, 1'b1);
        hold("t2", 8'hA5, 3, 1'b1);
        chk("t2:pre_valid", 32'(if0.out_valid), 32'd0);
        step("t2", 8'hA5, 1'b1);
        chk("t2:valid", 32'(if0.out_valid), 32'd1);
        chk("t2:data",  32'(if0.out_data),  32'hA5);
        chk("t2:pulse", 32'(cp0),           32'd1);
        step("t2", 8'hA5, 1'b1);
        chk("t2:valid_drop", 32'(if0.out_valid), 32'd0);
        chk("t2:pulse_drop", 32'(cp0),           32'd0);

        // 3: skew 00->81->A5 gives one commit of A5; glitch back to committed value ignored
        do_reset("t3");
        hold("t3", 8'h00, 3, 1'b1);
        step("t3", 8'h81, 1'b1);
        hold("t3", 8'hA5, 6, 1'b1);
        step("t3", 8'hFF, 1'b1);
        hold("t3", 8'hA5, 6, 1'b1);
        chk("t3:data", 32'(if0.out_data), 32'hA5);

        // 4: ready low, A5 then 3C -> one drop; ready on 77's commit edge
        do_reset("t4");
        hold("t4", 8'hA5, 5, 1'b0);
        hold("t4", 8'h3C, 5, 1'b0);
        chk("t4:data3c", 32'(if0.out_data), 32'h3C);
        chk("t4:drop1",  32'(drop0),        32'd1);
        hold("t4", 8'h77, 3, 1'b0);
        step("t4", 8'h77, 1'b1);
        chk("t4:data77", 32'(if0.out_data),  32'h77);
        chk("t4:valid",  32'(if0.out_valid), 32'd1);
        chk("t4:drop",   32'(drop0),         32'd1);

        // 5: five distinct commits, ready low -> 2-bit counter saturates at 3
        do_reset("t5");
        hold("t5", 8'h11, 4, 1'b0);
        hold("t5", 8'h22, 4, 1'b0);
        hold("t5", 8'h33, 4, 1'b0);
        hold("t5", 8'h44, 4, 1'b0);
        hold("t5", 8'h55, 4, 1'b0);
        chk("t5:drop2sat", 32'(drop2), 32'd3);
        chk("t5:drop16",   32'(drop0), 32'd4);

        // 6: reset while valid pending, then the same value commits again
        hold("t6", 8'h66, 4, 1'b0);
        chk("t6:pending", 32'(if0.out_valid), 32'd1);
        do_reset("t6");
        hold("t6", 8'h66, 4, 1'b0);
        chk("t6:recommit", 32'(if0.out_data),  32'h66);
        chk("t6:revalid",  32'(if0.out_valid), 32'd1);

        // random: values from a small pool with random hold lengths and ready
        for (int k = 0; k < 120; k++) begin
            logic [7:0] v;
            int         n;
            case ($urandom_range(0, 5))
                0: v = 8'h00;
                1: v = 8'hA5;
                2: v = 8'h3C;
                3: v = 8'h77;
                4: v = 8'hFF;
                default: v = 8'($urandom);
            endcase
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) step("rnd", v, 1'($urandom_range(0, 1)));
            if (k == 60) do_reset("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
